vc_output_scheduler: RTL and testbench

VC_OUTPUT_SCHEDULER -- requirements
Module: vc_output_scheduler

---
 rtl/vc_output_scheduler.sv | 212 +++++++++++++++++++++
 tb/tb_vc_output_scheduler.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vc_output_scheduler.sv
// vc_output_scheduler
//
// Output-side scheduler for a set of virtual-channel circular buffers. It
// picks one VC per cycle to pop, keeps a packet on one VC from head to tail
// (wormhole lock), and tracks downstream space with one credit counter per VC.
// Between packets the VCs are served round-robin, with the search starting one
// past the VC that most recently finished a packet.
//
// Flit type lives in the top two flit bits: 00 HEAD, 01 BODY, 10 TAIL,
// 11 HEADTAIL.
//
// Parameters
//   VC_NUM       number of VC buffers served (>= 2)
//   BUFFER_SIZE  downstream buffer depth per VC, also the reset credit count
//   FLIT_SIZE    flit width in bits
//
// Ports
//   clk           clock, rising-edge
//   rst           synchronous active-high reset
//   data_i        head flit of each VC buffer, VC v in [v*FLIT_SIZE +: FLIT_SIZE]
//   is_empty_i    per-VC buffer-empty flags
//   read_o        per-VC pop strobe (combinational, one-hot or zero)
//   credit_i      per-VC one-cycle pulse: downstream freed one slot
//   data_o        forwarded flit (registered)
//   valid_o       data_o carries a flit this cycle (registered)
//   vc_o          VC index of data_o (registered)
//   flit_count_o  forwarded-flit counter
//
// Optional feature
//   VC_SCHED_STATS_EN  when defined, flit_count_o counts forwarded flits
//                      (16-bit, wrapping); otherwise it is tied to zero and no
//                      counter is built.

module vc_output_scheduler #(
  parameter int VC_NUM      = 2,
  parameter int BUFFER_SIZE = 8,
  parameter int FLIT_SIZE   = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [VC_NUM*FLIT_SIZE-1:0]   data_i,
  input  logic [VC_NUM-1:0]             is_empty_i,
  output logic [VC_NUM-1:0]             read_o,
  input  logic [VC_NUM-1:0]             credit_i,
  output logic [FLIT_SIZE-1:0]          data_o,
  output logic                          valid_o,
  output logic [$clog2(VC_NUM)-1:0]     vc_o,
  output logic [15:0]                   flit_count_o
);

  localparam int VW = $clog2(VC_NUM);
  localparam int CW = $clog2(BUFFER_SIZE + 1);

  localparam logic [1:0] T_HEAD     = 2'b00;
  localparam logic [1:0] T_TAIL     = 2'b10;
  localparam logic [1:0] T_HEADTAIL = 2'b11;

  localparam logic [CW-1:0] CRED_MAX = CW'(BUFFER_SIZE);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t          state_r;
  logic [VW-1:0]   lock_vc_r;
  logic [VW-1:0]   ptr_r;
  logic [CW-1:0]   credit_r [VC_NUM];

  logic [VC_NUM-1:0]    sendable_s;
  logic [VC_NUM-1:0]    eligible_s;
  logic                 grant_s;
  logic [VW-1:0]        grant_vc_s;
  logic [FLIT_SIZE-1:0] grant_flit_s;
  logic [1:0]           grant_type_s;
  logic [VW-1:0]        next_ptr_s;

  // Per-VC readiness: sendable needs data and credit; eligible (packet start)
  // additionally needs a HEAD or HEADTAIL flit at the buffer head.
  always_comb begin
    logic [1:0] ht;
    sendable_s = '0;
    eligible_s = '0;
    ht         = 2'b00;
    for (int v = 0; v < VC_NUM; v++) begin
      ht            = data_i[v*FLIT_SIZE + FLIT_SIZE - 2 +: 2];
      sendable_s[v] = ~is_empty_i[v] & (credit_r[v] != '0);
      eligible_s[v] = sendable_s[v] & ((ht == T_HEAD) | (ht == T_HEADTAIL));
    end
  end

  // Grant selection: round-robin search from ptr_r when idle, otherwise only
  // the locked VC may move, and only when it is sendable.
  always_comb begin
    int idx;
    grant_s    = 1'b0;
    grant_vc_s = '0;
    idx        = 0;
    if (state_r == ST_IDLE) begin
      for (int i = 0; i < VC_NUM; i++) begin
        idx = (int'(ptr_r) + i) % VC_NUM;
        if (!grant_s && eligible_s[idx]) begin
          grant_s    = 1'b1;
          grant_vc_s = VW'(idx);
        end else begin
          grant_s    = grant_s;
        end
      end
    end else begin
      grant_vc_s = lock_vc_r;
      grant_s    = sendable_s[lock_vc_r];
    end
  end

  // Flit being popped this cycle and the pointer value that follows it.
  always_comb begin
    grant_flit_s = data_i[int'(grant_vc_s)*FLIT_SIZE +: FLIT_SIZE];
    grant_type_s = grant_flit_s[FLIT_SIZE-1 -: 2];
    if (int'(grant_vc_s) == VC_NUM - 1) begin
      next_ptr_s = '0;
    end else begin
      next_ptr_s = grant_vc_s + VW'(1);
    end
  end

  // Pop strobe; reset suppresses any read so an in-flight packet is dropped.
  always_comb begin
    read_o = '0;
    if (grant_s && !rst) begin
      read_o[grant_vc_s] = 1'b1;
    end else begin
      read_o = '0;
    end
  end

  // Credit counters: a pop and a returned credit in the same cycle cancel;
  // a credit returned to an already-full counter is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int v = 0; v < VC_NUM; v++) begin
        credit_r[v] <= CRED_MAX;
      end
    end else begin
      for (int v = 0; v < VC_NUM; v++) begin
        if (read_o[v] && credit_i[v]) begin
          credit_r[v] <= credit_r[v];
        end else if (read_o[v]) begin
          credit_r[v] <= credit_r[v] - CW'(1);
        end else if (credit_i[v] && (credit_r[v] != CRED_MAX)) begin
          credit_r[v] <= credit_r[v] + CW'(1);
        end else begin
          credit_r[v] <= credit_r[v];
        end
      end
    end
  end

  // Packet-lock FSM, round-robin pointer and registered output stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      lock_vc_r <= '0;
      ptr_r     <= '0;
      valid_o   <= 1'b0;
      data_o    <= '0;
      vc_o      <= '0;
    end else begin
      valid_o <= grant_s;
      if (grant_s) begin
        data_o <= grant_flit_s;
        vc_o   <= grant_vc_s;
      end
      case (state_r)
        ST_IDLE: begin
          if (grant_s && (grant_type_s == T_HEAD)) begin
            state_r   <= ST_LOCKED;
            lock_vc_r <= grant_vc_s;
          end else if (grant_s && (grant_type_s == T_HEADTAIL)) begin
            ptr_r <= next_ptr_s;
          end
        end
        ST_LOCKED: begin
          if (grant_s && (grant_type_s == T_TAIL)) begin
            state_r <= ST_IDLE;
            ptr_r   <= next_ptr_s;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef VC_SCHED_STATS_EN
  logic [15:0] flit_count_r;

  // One count per forwarded flit, wrapping naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      flit_count_r <= 16'h0000;
    end else if (grant_s) begin
      flit_count_r <= flit_count_r + 16'h0001;
    end
  end

  assign flit_count_o = flit_count_r;
`else
  assign flit_count_o = 16'h0000;
`endif

endmodule

// File: tb/tb_vc_output_scheduler.sv
// Testbench for vc_output_scheduler (VC_NUM=2, BUFFER_SIZE=8, FLIT_SIZE=8).
// The bench owns the upstream VC buffers as queues and a reference model of
// the scheduling rules; expected forwarded flits go into a scoreboard that a
// separate monitor drains as the DUT presents them.

module tb_vc_output_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] data_i;
  logic [1:0]  is_empty_i;
  logic [1:0]  read_o;
  logic [1:0]  credit_i;
  logic [7:0]  data_o;
  logic        valid_o;
  logic [0:0]  vc_o;
  logic [15:0] flit_count_o;

  always #5 clk = ~clk;

  vc_output_scheduler #(.VC_NUM(2), .BUFFER_SIZE(8), .FLIT_SIZE(8)) dut (
    .clk(clk), .rst(rst), .data_i(data_i), .is_empty_i(is_empty_i),
    .read_o(read_o), .credit_i(credit_i), .data_o(data_o), .valid_o(valid_o),
    .vc_o(vc_o), .flit_count_o(flit_count_o)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit mon_on  = 1'b0;

  // upstream buffers
  logic [7:0] q0[$];
  logic [7:0] q1[$];

  // reference model: -1 means no packet in progress
  int m_lock;
  int m_ptr;
  int m_cred[2];
  int m_cnt;
  int occ[2];
  logic [1:0] last_rd;

  typedef struct {
    int         tag;
    logic [7:0] d;
    int         vc;
  } exp_t;
  exp_t sb[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  function automatic bit has(input int v);
    return (v == 0) ? (q0.size() > 0) : (q1.size() > 0);
  endfunction

  function automatic logic [7:0] front(input int v);
    return (v == 0) ? q0[0] : q1[0];
  endfunction

  // which VC the rules say should be popped now, -1 for none
  function automatic int model_pick();
    logic [7:0] f;
    int v;
    if (rst) return -1;
    if (m_lock >= 0) return (has(m_lock) && m_cred[m_lock] > 0) ? m_lock : -1;
    for (int i = 0; i < 2; i++) begin
      v = (m_ptr + i) % 2;
      if (has(v) && m_cred[v] > 0) begin
        f = front(v);
        if (f[7:6] == 2'b00 || f[7:6] == 2'b11) return v;
      end
    end
    return -1;
  endfunction

  // one clock cycle: drive inputs, check the pop decision, advance the model
  task automatic step(input logic [1:0] cred);
    int e;
    logic [7:0] f;
    logic [1:0] t;
    credit_i      = cred;
    is_empty_i    = {q1.size() == 0, q0.size() == 0};
    data_i[7:0]   = (q0.size() > 0) ? q0[0] : 8'($urandom);
    data_i[15:8]  = (q1.size() > 0) ? q1[0] : 8'($urandom);
    @(negedge clk);
    e = model_pick();
    f = (e >= 0) ? front(e) : 8'h00;
    chk("read_o", {30'd0, read_o}, (e < 0) ? 32'd0 : (32'd1 << e));
    last_rd = read_o;
    if (e >= 0) sb.push_back('{cyc, f, e});
    @(posedge clk);
    if (rst) begin
      m_lock = -1; m_ptr = 0; m_cnt = 0;
      for (int v = 0; v < 2; v++) begin m_cred[v] = 8; occ[v] = 0; end
    end else begin
      for (int v = 0; v < 2; v++) begin
        if (e == v && !cred[v]) m_cred[v]--;
        else if (e != v && cred[v] && m_cred[v] < 8) m_cred[v]++;
      end
      if (e >= 0) begin
        t = f[7:6];
        occ[e]++;
        m_cnt = (m_cnt + 1) % 65536;
        if (m_lock < 0) begin
          if (t == 2'b00) m_lock = e;
          else if (t == 2'b11) m_ptr = (e + 1) % 2;
        end else if (t == 2'b10) begin
          m_lock = -1;
          m_ptr  = (e + 1) % 2;
        end
        if (e == 0) void'(q0.pop_front()); else void'(q1.pop_front());
      end
    end
    #1;
  endtask

  task automatic do_reset();
    q0.delete(); q1.delete();
    rst = 1'b1;
    step(2'b00);
    rst = 1'b0;
  endtask

  task automatic push_pkt(input int v, input int len);
    logic [7:0] f;
    for (int i = 0; i < len; i++) begin
      f[5:0] = 6'($urandom);
      if (len == 1) f[7:6] = 2'b11;
      else if (i == 0) f[7:6] = 2'b00;
      else if (i == len - 1) f[7:6] = 2'b10;
      else f[7:6] = 2'b01;
      if (v == 0) q0.push_back(f); else q1.push_back(f);
    end
  endtask

  // monitor: every presented flit must match the oldest expectation
  always @(negedge clk) begin
    exp_t x;
    if (mon_on) begin
      if (valid_o === 1'b1) begin
        if (sb.size() == 0 || sb[0].tag != cyc - 1) begin
          fail_now("unexpected valid_o");
        end else begin
          x = sb.pop_front();
          chk("data_o", {24'd0, data_o}, {24'd0, x.d});
          chk("vc_o", {31'd0, vc_o}, x.vc);
        end
      end else if (sb.size() > 0 && sb[0].tag == cyc - 1) begin
        x = sb.pop_front();
        chk("valid_o", {31'd0, valid_o}, 32'd1);
      end
`ifdef VC_SCHED_STATS_EN
      chk("flit_count_o", {16'd0, flit_count_o}, m_cnt);
`else
      chk("flit_count_o", {16'd0, flit_count_o}, 32'd0);
`endif
    end
  end

  logic [1:0] seq[$];
  int cnt;

  initial begin
    logic [1:0] cr;
    rst = 1'b1; credit_i = 2'b00; data_i = 16'h0000; is_empty_i = 2'b11;
    m_lock = -1; m_ptr = 0; m_cnt = 0; last_rd = 2'b00;
    for (int v = 0; v < 2; v++) begin m_cred[v] = 8; occ[v] = 0; end
    step(2'b00);
    step(2'b00);
    mon_on = 1'b1;
    chk("reset valid_o", {31'd0, valid_o}, 32'd0);
    chk("reset data_o", {24'd0, data_o}, 32'd0);
    chk("reset vc_o", {31'd0, vc_o}, 32'd0);
    chk("reset flit_count_o", {16'd0, flit_count_o}, 32'd0);
    rst = 1'b0;

    // three-flit packet on VC0
    q0.push_back(8'h05); q0.push_back(8'h45); q0.push_back(8'h85);
    for (int i = 0; i < 3; i++) begin
      step(2'b00);
      chk("pkt0 read", {30'd0, last_rd}, 32'd1);
    end
    step(2'b00); step(2'b00);

    // HEADTAIL on both VCs: alternation starting from VC1 (pointer moved to 1)
    for (int i = 0; i < 3; i++) begin
      q0.push_back(8'hC1 + 8'(i)); q1.push_back(8'hD1 + 8'(i));
    end
    for (int i = 0; i < 6; i++) begin
      step(2'b00);
      chk("alternate", {30'd0, last_rd}, (i % 2 == 0) ? 32'd2 : 32'd1);
    end

    // VC0 locked and starved while VC1 waits with a HEAD
    q0.push_back(8'h01);
    step(2'b00);
    chk("lock head", {30'd0, last_rd}, 32'd1);
    q1.push_back(8'h11); q1.push_back(8'h92);
    for (int i = 0; i < 4; i++) begin
      step(2'b01);
      chk("locked stall", {30'd0, last_rd}, 32'd0);
    end
    q0.push_back(8'h42); q0.push_back(8'h83);
    seq = '{2'b01, 2'b01, 2'b10, 2'b10};
    foreach (seq[i]) begin
      step(2'b00);
      chk("unlock order", {30'd0, last_rd}, {30'd0, seq[i]});
    end

    // credit exhaustion on VC1
    do_reset();
    push_pkt(1, 9);
    cnt = 0;
    repeat (12) begin step(2'b00); cnt += int'(last_rd[1]); end
    chk("vc1 reads w/o credit", cnt, 32'd8);
    cnt = 0;
    step(2'b10); cnt += int'(last_rd[1]);
    repeat (4) begin step(2'b00); cnt += int'(last_rd[1]); end
    chk("vc1 reads after 1 credit", cnt, 32'd1);

    // simultaneous pop and credit at 5 credits leaves 5
    do_reset();
    q0.push_back(8'h07); q0.push_back(8'h47); q0.push_back(8'h48); q0.push_back(8'h49);
    repeat (3) step(2'b00);
    step(2'b01);
    chk("pop+credit read", {30'd0, last_rd}, 32'd1);
    for (int i = 0; i < 5; i++) q0.push_back(8'h50 + 8'(i));
    q0.push_back(8'h9F);
    cnt = 0;
    repeat (9) begin step(2'b00); cnt += int'(last_rd[0]); end
    chk("reads at 5 credits", cnt, 32'd5);
    step(2'b01);
    repeat (3) step(2'b00);

    // credit pulse at full credit is dropped
    do_reset();
    step(2'b01);
    push_pkt(0, 9);
    cnt = 0;
    repeat (12) begin step(2'b00); cnt += int'(last_rd[0]); end
    chk("reads after saturating credit", cnt, 32'd8);

    // reset while locked drops the packet; orphan BODY is never granted
    do_reset();
    q0.push_back(8'h0A); q0.push_back(8'h4A); q0.push_back(8'h4B);
    step(2'b00);
    rst = 1'b1;
    step(2'b00);
    rst = 1'b0;
    chk("valid_o after reset", {31'd0, valid_o}, 32'd0);
    cnt = 0;
    repeat (4) begin step(2'b00); cnt += int'(last_rd != 2'b00); end
    chk("orphan body not granted", cnt, 32'd0);

    // randomized traffic with random credit return
    do_reset();
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 699) == 0) begin
        do_reset();
      end else begin
        if ($urandom_range(0, 3) == 0) begin
          int v;
          v = int'($urandom_range(0, 1));
          if ((v == 0 ? q0.size() : q1.size()) < 12) push_pkt(v, int'($urandom_range(1, 4)));
        end
        cr = 2'b00;
        for (int v = 0; v < 2; v++) begin
          if (occ[v] > 0 && $urandom_range(0, 2) == 0) begin
            cr[v] = 1'b1;
            occ[v]--;
          end else if (occ[v] == 0 && $urandom_range(0, 49) == 0) begin
            cr[v] = 1'b1;
          end
        end
        step(cr);
      end
    end
    step(2'b00); step(2'b00);
    if (sb.size() != 0) fail_now("scoreboard not drained");
    mon_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
